// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared key codes, entry states and PIN width for the parking gate
package parking_pkg;

    localparam int PIN_W = 8;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_D0,
        ST_D1,
        ST_D2,
        ST_SEND
    } entry_state_t;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

endpackage

// File: rtl/inactivity_timer.sv
// rtl/inactivity_timer.sv - saturating idle counter, expired once LIMIT-1 cycles have been counted
module inactivity_timer #(
    parameter int LIMIT = 200
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Clear wins over enable; holding at LAST keeps the counter from wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/keypad_code_entry.sv
// rtl/keypad_code_entry.sv - collects two BCD keypad digits into a PIN word and pulses sEnter
module keypad_code_entry
    import parking_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200,
    parameter int ENTER_CYCLES   = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sEntrada,
    input  logic             sTeclaValida,
    input  logic [3:0]       sTecla,
    output logic [PIN_W-1:0] sCode,
    output logic             sEnter,
    output logic [1:0]       sDigitos,
    output logic             sError
);

    localparam int SW = (ENTER_CYCLES > 1) ? $clog2(ENTER_CYCLES) : 1;
    localparam logic [SW-1:0] SEND_LAST = SW'(ENTER_CYCLES - 1);

    entry_state_t     state_q, state_d;
    logic [PIN_W-1:0] buf_q, buf_d;
    logic [PIN_W-1:0] code_q, code_d;
    logic [SW-1:0]    send_cnt_q, send_cnt_d;
    logic             enter_q, enter_d;
    logic             err_q, err_d;
    logic [1:0]       dig_q, dig_d;

    logic key_acc;
    logic timeout;
    logic tmr_expired;
    logic collecting_digits;

    assign collecting_digits = (state_q == ST_D1) || (state_q == ST_D2);

    inactivity_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk_i    (clock),
        .rst_i    (reset),
        .clr_i    (!collecting_digits || key_acc || timeout || !sEntrada),
        .en_i     (collecting_digits),
        .expired_o(tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        code_d     = code_q;
        send_cnt_d = send_cnt_q;
        enter_d    = 1'b0;
        err_d      = 1'b0;
        key_acc    = 1'b0;
        timeout    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sEntrada) begin
                    state_d = ST_D0;
                end
            end
            ST_SEND: begin
                enter_d = 1'b1;
                err_d   = sTeclaValida;
                if (send_cnt_q == SEND_LAST) begin
                    enter_d    = 1'b0;
                    buf_d      = '0;
                    send_cnt_d = '0;
                    state_d    = sEntrada ? ST_D0 : ST_IDLE;
                end else begin
                    send_cnt_d = send_cnt_q + 1'b1;
                end
            end
            ST_D0, ST_D1, ST_D2: begin
                // Losing the vehicle outranks any key arriving in the same cycle.
                if (!sEntrada) begin
                    state_d = ST_IDLE;
                    buf_d   = '0;
                end else if (sTeclaValida) begin
                    if (is_digit(sTecla)) begin
                        if (state_q == ST_D0) begin
                            buf_d[7:4] = sTecla;
                            state_d    = ST_D1;
                            key_acc    = 1'b1;
                        end else if (state_q == ST_D1) begin
                            buf_d[3:0] = sTecla;
                            state_d    = ST_D2;
                            key_acc    = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (sTecla == KEY_CLEAR) begin
                        buf_d   = '0;
                        state_d = ST_D0;
                        key_acc = 1'b1;
                    end else if (sTecla == KEY_ENTER) begin
                        if (state_q == ST_D2) begin
                            code_d     = buf_q;
                            enter_d    = 1'b1;
                            send_cnt_d = '0;
                            state_d    = ST_SEND;
                            key_acc    = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (tmr_expired && collecting_digits) begin
                    timeout = 1'b1;
                    buf_d   = '0;
                    state_d = ST_D0;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_D1:   dig_d = 2'd1;
            ST_D2:   dig_d = 2'd2;
            default: dig_d = 2'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            buf_q      <= '0;
            code_q     <= '0;
            send_cnt_q <= '0;
            enter_q    <= 1'b0;
            err_q      <= 1'b0;
            dig_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            code_q     <= code_d;
            send_cnt_q <= send_cnt_d;
            enter_q    <= enter_d;
            err_q      <= err_d;
            dig_q      <= dig_d;
        end
    end

    assign sCode    = code_q;
    assign sEnter   = enter_q;
    assign sDigitos = dig_q;
    assign sError   = err_q;

endmodule

// File: doc/keypad_code_entry.md
# keypad_code_entry

- Upstream stage of the parking-entrance gate controller: turns keypad strobes into the 8-bit PIN word `sCode` and the `sEnter` pulse the controller consumes.
- Collects exactly two BCD digits per attempt, first digit in the high nibble; the PIN 3-8 is presented as 8'h38.
- Accepts keys only while a vehicle sits at the entrance.
- Discards stale partial entries after an inactivity timeout.

## Interface
- `TIMEOUT_CYCLES`, default 200: idle cycles after the last accepted key before a partial entry is discarded (≥ 2).
- `ENTER_CYCLES`, default 2: length of the `sEnter` pulse in clock cycles (≥ 1).
- One clock; reset is synchronous and active-high.
- `clock`  in  1  system clock, all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `sEntrada`  in  1  vehicle-at-entrance sensor; entry enabled only while high.
- `sTeclaValida`  in  1  single-cycle key strobe from the keypad scanner.
- `sTecla`  in  4  key code:
  - 0–9: digit.
  - 4'hA: clear.
  - 4'hB: enter.
  - 4'hC–4'hF: invalid.
- `sCode`  out  8  PIN word {digit1, digit2}; registered, changes only when an entry is sent.
- `sEnter`  out  1  high for `ENTER_CYCLES` cycles per sent entry.
- `sDigitos`  out  2  digits currently buffered (0..2), for the display.
- `sError`  out  1  one-cycle pulse on each rejected key.

## Operation
- States: IDLE, D0, D1, D2, SEND.
- Reset values: state IDLE, `sCode`=8'h00, `sEnter`=0, `sDigitos`=0, `sError`=0, buffer 8'h00, timer 0.
- IDLE → D0 when `sEntrada`=1. Strobes in IDLE are ignored silently (no `sError`).
- Any state except SEND → IDLE when `sEntrada`=0; the buffer is cleared. This has priority over a same-cycle strobe.
- Digit handling:
  - D0: store in buffer[7:4], go to D1.
  - D1: store in buffer[3:0], go to D2.
  - D2: `sError`; buffer unchanged, no overwrite.
- Enter handling:
  - D2: `sCode` ← buffer, go to SEND.
  - D0 or D1: `sError`; state and buffer unchanged.
- Clear (4'hA) in D0/D1/D2: buffer ← 0, go to D0, no error.
- Codes 4'hC–4'hF in D0/D1/D2: `sError`, no other effect.
- SEND:
  - `sEnter` held high for `ENTER_CYCLES` cycles.
  - Strobes are rejected with `sError`.
  - Always completes, even if `sEntrada` falls.
  - On exit: buffer cleared; go to D0 if `sEntrada`=1, else IDLE. `sCode` keeps the sent value.
- Inactivity timer:
  - Runs in D1/D2 only; cleared by any accepted key and on entering D1.
  - When it reaches `TIMEOUT_CYCLES`-1 with no strobe that cycle: buffer cleared, go to D0, `sError` pulse.
  - A strobe in the same cycle wins; the timeout is not taken.
  - Width is $clog2(`TIMEOUT_CYCLES`); the timer saturates, never wraps.
- `sDigitos` = 0 in IDLE/D0/SEND, 1 in D1, 2 in D2.

## Timing
- All outputs are registered. A strobe sampled at edge t takes effect at t+1.
- Enter strobe accepted at edge t:
  - `sCode` valid from t+1.
  - `sEnter` high over cycles t+1 .. t+`ENTER_CYCLES`.
  - Next key accepted from edge t+`ENTER_CYCLES`+1.
- `sError` is high exactly the cycle after the rejected strobe or timeout.
- Back-to-back strobes on consecutive cycles are all processed; no holdoff.
- Reset asserted mid-SEND drops `sEnter` at the next edge. `sCode` returns to 8'h00.
- `sTecla` is sampled only when `sTeclaValida`=1.

## Structure
- Shared package `parking_pkg`:
  - Key-code constants KEY_CLEAR=4'hA and KEY_ENTER=4'hB.
  - State enum for IDLE/D0/D1/D2/SEND.
  - PIN width constant (8). The gate controller imports the same package.
- One natural sub-module, `inactivity_timer`: parameterised saturating counter with clear/enable inputs and an `expired` output. Reused later by the gate-open timeout.
- Estimated 150–250 lines of RTL.

## Test plan
- Basic send: `sEntrada`=1; keys 3, 8, B → `sDigitos` 1 then 2; `sCode`=8'h38; `sEnter` high exactly 2 cycles; no `sError`.
- Premature enter and overflow:
  - Keys 5, B → `sError` pulse, state stays D1.
  - Then 6, 7 → `sError` on the 7; `sCode` after a later B = 8'h56.
- Clear and invalid keys: keys 1, A, D, 3, 8, B → no error on A, `sError` on D, `sCode`=8'h38.
- Timeout (`TIMEOUT_CYCLES`=10):
  - Key 4, then 10 idle cycles → `sError`, `sDigitos`=0.
  - A strobe exactly on the expiring cycle is accepted and restarts the timer.
- Sensor drop:
  - Keys 3, 8, then `sEntrada`=0 together with key B → IDLE, no `sEnter`.
  - `sEntrada` falling during SEND → `sEnter` pulse still completes, then IDLE.
- Reset mid-operation: reset pulsed on the first `sEnter` cycle → next edge all outputs 0, state IDLE; keys 3, 8, B afterwards give a normal send.
